// File: rtl/add_sub_pipe.sv
// Pipelined add/subtract unit: the carry chain is cut into SEG_W-bit segments, one per stage,
// joined by an elastic valid/ready pipeline. Produces result plus carry/overflow/zero/negative flags.
module add_sub_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       op_i,
  input  logic             cin_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o,
  output logic             neg_o
);

  localparam int unsigned NSEG = WIDTH / SEG_W;

  logic [WIDTH-1:0] bx_in;
  logic             c0_in;
  logic [NSEG-1:0]  stage_v;
  logic [NSEG-1:0]  load_en;
  logic             cmsb_q;
  logic             zero_q;

  always_comb begin
    bx_in = op_i[0] ? ~b_i : b_i;
    c0_in = cin_i;
    if (op_i == 2'b00) begin
      c0_in = 1'b0;
    end else if (op_i == 2'b01) begin
      c0_in = 1'b1;
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    // IW: operand bits still unresolved on entry; RW: result bits known after this stage.
    localparam int unsigned IW = WIDTH - k * SEG_W;
    localparam int unsigned RW = (k + 1) * SEG_W;

    logic [IW-1:0]  src_a;
    logic [IW-1:0]  src_bx;
    logic           src_c;
    logic           src_v;
    logic [SEG_W:0] seg_sum;
    logic [RW-1:0]  nxt_res;
    logic [RW-1:0]  res_q;
    logic           c_q;
    logic           v_q;

    // Closed form of "empty, or the stage after us moves": avoids a combinational chain.
    assign load_en[k] = ready_i | ~(&stage_v[NSEG-1:k]);
    assign stage_v[k] = v_q;
    assign seg_sum    = {1'b0, src_a[SEG_W-1:0]} + {1'b0, src_bx[SEG_W-1:0]}
                      + {{SEG_W{1'b0}}, src_c};

    if (k == 0) begin : g_head
      assign src_a   = a_i;
      assign src_bx  = bx_in;
      assign src_c   = c0_in;
      assign src_v   = valid_i;
      assign nxt_res = seg_sum[SEG_W-1:0];
    end else begin : g_body
      assign src_a   = g_stage[k-1].g_fwd.a_q;
      assign src_bx  = g_stage[k-1].g_fwd.bx_q;
      assign src_c   = g_stage[k-1].c_q;
      assign src_v   = g_stage[k-1].v_q;
      assign nxt_res = {seg_sum[SEG_W-1:0], g_stage[k-1].res_q};
    end

    // Bubbles only clear the valid bit; data registers keep their old contents.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        res_q <= '0;
      end else if (load_en[k]) begin
        v_q <= src_v;
        if (src_v) begin
          c_q   <= seg_sum[SEG_W];
          res_q <= nxt_res;
        end
      end
    end

    if (k < NSEG - 1) begin : g_fwd
      logic [IW-SEG_W-1:0] a_q;
      logic [IW-SEG_W-1:0] bx_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          a_q  <= '0;
          bx_q <= '0;
        end else if (load_en[k] && src_v) begin
          a_q  <= src_a[IW-1:SEG_W];
          bx_q <= src_bx[IW-1:SEG_W];
        end
      end
    end else begin : g_tail
      // Carry into the MSB is recovered from the MSB sum bit and its two addend bits.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cmsb_q <= 1'b0;
          zero_q <= 1'b0;
        end else if (load_en[k] && src_v) begin
          cmsb_q <= src_a[SEG_W-1] ^ src_bx[SEG_W-1] ^ seg_sum[SEG_W-1];
          zero_q <= (nxt_res == '0);
        end
      end
    end
  end

  assign ready_o  = load_en[0];
  assign valid_o  = stage_v[NSEG-1];
  assign result_o = g_stage[NSEG-1].res_q;
  assign cout_o   = g_stage[NSEG-1].c_q;
  assign ovf_o    = cmsb_q ^ g_stage[NSEG-1].c_q;
  assign zero_o   = zero_q;
  assign neg_o    = g_stage[NSEG-1].res_q[WIDTH-1];

endmodule

// File: tb/tb_add_sub_pipe.sv
// Self-checking bench for add_sub_pipe (WIDTH=32, SEG_W=8): scoreboard of expected beats,
// directed flag cases, backpressure, carry chaining, random streams and mid-flight reset.
module tb_add_sub_pipe;

  localparam int NSEG = 4;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } flags_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [1:0]  op_i;
  logic        cin_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        cout_o;
  logic        ovf_o;
  logic        zero_o;
  logic        neg_o;

  always #5 clk = ~clk;

  add_sub_pipe #(.WIDTH(32), .SEG_W(8)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .a_i      (a_i),
    .b_i      (b_i),
    .op_i     (op_i),
    .cin_i    (cin_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .cout_o   (cout_o),
    .ovf_o    (ovf_o),
    .zero_o   (zero_o),
    .neg_o    (neg_o)
  );

  int checks = 0;
  int errors = 0;

  flags_t      exp_q[$];
  flags_t      got_q[$];
  flags_t      want_q[$];
  logic [31:0] st_a[$];
  logic [31:0] st_b[$];
  logic [1:0]  st_op[$];
  logic        st_cin[$];

  int unstable;
  int ready_low_depth;
  int run_cycles;
  int first_lat;
  bit timed_out;

  function automatic flags_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [1:0] op, input logic cin);
    flags_t      m;
    logic [31:0] bx;
    logic        c;
    logic [32:0] full;
    logic [31:0] low;
    bx   = op[0] ? ~b : b;
    c    = (op == 2'b00) ? 1'b0 : (op == 2'b01) ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, bx} + {32'd0, c};
    low  = {1'b0, a[30:0]} + {1'b0, bx[30:0]} + {31'd0, c};
    m.res = full[31:0];
    m.c   = full[32];
    m.v   = low[31] ^ full[32];
    m.z   = (full[31:0] == 32'd0);
    m.n   = full[31];
    return m;
  endfunction

  task automatic clear_stim();
    st_a.delete();
    st_b.delete();
    st_op.delete();
    st_cin.delete();
  endtask

  task automatic add_beat(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input logic cin);
    st_a.push_back(a);
    st_b.push_back(b);
    st_op.push_back(op);
    st_cin.push_back(cin);
  endtask

  // Drives queued beats, scoreboards results; entered and left at posedge+1.
  task automatic run_beats(input int stall_lo, input int stall_hi, input bit rand_ready,
                           input int max_cycles);
    int     idx = 0;
    int     cyc = 0;
    int     first_in = -1;
    int     first_out = -1;
    bit     prev_stall = 1'b0;
    flags_t obs;
    flags_t prev;
    unstable = 0;
    ready_low_depth = -1;
    got_q.delete();
    want_q.delete();
    exp_q.delete();
    while ((idx < st_a.size() || exp_q.size() != 0) && cyc < max_cycles) begin
      if (rand_ready) ready_i = ($urandom_range(0, 3) != 0);
      else ready_i = !(cyc >= stall_lo && cyc <= stall_hi);
      valid_i = (idx < st_a.size());
      if (valid_i) begin
        a_i   = st_a[idx];
        b_i   = st_b[idx];
        op_i  = st_op[idx];
        cin_i = st_cin[idx];
      end
      @(negedge clk);
      obs = {result_o, cout_o, ovf_o, zero_o, neg_o};
      if (valid_o && !ready_i) begin
        if (prev_stall && obs !== prev) unstable++;
        prev = obs;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (!ready_o && ready_low_depth < 0) ready_low_depth = exp_q.size();
      if (valid_o && ready_i) begin
        got_q.push_back(obs);
        if (exp_q.size() != 0) want_q.push_back(exp_q.pop_front());
        else want_q.push_back('x);
        if (first_out < 0) first_out = cyc;
      end
      if (valid_i && ready_o) begin
        exp_q.push_back(model(a_i, b_i, op_i, cin_i));
        idx++;
        if (first_in < 0) first_in = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    valid_i    = 1'b0;
    ready_i    = 1'b1;
    timed_out  = (cyc >= max_cycles);
    run_cycles = cyc;
    first_lat  = first_out - first_in;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b want 0", valid_o);
    end
    checks++;
    if ({result_o, cout_o, ovf_o, zero_o, neg_o} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {result_o, cout_o, ovf_o, zero_o, neg_o});
    end
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", ready_o);
    end
  endtask

  task automatic test_add_wrap();
    flags_t want;
    want = {32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    clear_stim();
    add_beat(32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 1'b1);
    run_beats(1, 0, 1'b0, 40);
    checks++;
    if (timed_out || got_q.size() != 1) begin
      errors++;
      $display("FAIL add_wrap_count: got %0d beats (timeout %0b) want 1", got_q.size(), timed_out);
    end
    checks++;
    if (got_q[0] !== want) begin
      errors++;
      $display("FAIL add_wrap_value: got %h want %h", got_q[0], want);
    end
    checks++;
    if (first_lat != NSEG) begin
      errors++;
      $display("FAIL add_wrap_latency: got %0d want %0d", first_lat, NSEG);
    end
  endtask

  task automatic test_sub_ovf();
    flags_t want [3];
    want[0] = {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    want[1] = {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    want[2] = {32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    clear_stim();
    add_beat(32'd5, 32'd7, 2'b01, 1'b0);
    add_beat(32'h8000_0000, 32'h0000_0001, 2'b01, 1'b0);
    add_beat(32'h7FFF_FFFF, 32'h0000_0000, 2'b10, 1'b1);
    run_beats(1, 0, 1'b0, 40);
    checks++;
    if (timed_out || got_q.size() != 3) begin
      errors++;
      $display("FAIL sub_count: got %0d beats (timeout %0b) want 3", got_q.size(), timed_out);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_q[i] !== want[i]) begin
        errors++;
        $display("FAIL sub_value[%0d]: got %h want %h", i, got_q[i], want[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_stim();
    for (int i = 0; i < 6; i++) add_beat(32'(i), 32'(i) * 32'h0101_0101, 2'b00, 1'b0);
    run_beats(3, 8, 1'b0, 60);
    checks++;
    if (timed_out || got_q.size() != 6) begin
      errors++;
      $display("FAIL bp_count: got %0d beats (timeout %0b) want 6", got_q.size(), timed_out);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got_q[i] !== want_q[i] || got_q[i].res !== 32'(i) * 32'h0101_0102) begin
        errors++;
        $display("FAIL bp_value[%0d]: got %h want %h", i, got_q[i], want_q[i]);
      end
    end
    checks++;
    if (ready_low_depth != NSEG) begin
      errors++;
      $display("FAIL bp_ready_depth: got %0d want %0d", ready_low_depth, NSEG);
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d changes while stalled want 0", unstable);
    end
  endtask

  task automatic test_chain();
    logic carry;
    clear_stim();
    add_beat(32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 1'b0);
    run_beats(1, 0, 1'b0, 40);
    carry = got_q[0].c;
    checks++;
    if (got_q.size() != 1 || got_q[0].res !== 32'd0 || carry !== 1'b1) begin
      errors++;
      $display("FAIL chain_low: got %h want res 0 carry 1", got_q[0]);
    end
    clear_stim();
    add_beat(32'h0000_0001, 32'h0000_0000, 2'b10, carry);
    run_beats(1, 0, 1'b0, 40);
    checks++;
    if (got_q.size() != 1 || got_q[0].res !== 32'h0000_0002) begin
      errors++;
      $display("FAIL chain_high: got %h want res 2", got_q[0]);
    end
  endtask

  task automatic test_back_to_back();
    clear_stim();
    for (int i = 0; i < 20; i++) add_beat($urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom));
    run_beats(1, 0, 1'b0, 100);
    checks++;
    if (got_q.size() != 20 || run_cycles != 20 + NSEG) begin
      errors++;
      $display("FAIL b2b_throughput: got %0d beats in %0d cycles want 20 in %0d",
               got_q.size(), run_cycles, 20 + NSEG);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (got_q[i] !== want_q[i]) begin
        errors++;
        $display("FAIL b2b_value[%0d]: got %h want %h", i, got_q[i], want_q[i]);
      end
    end
  endtask

  task automatic test_random_stall();
    clear_stim();
    for (int i = 0; i < 24; i++) add_beat($urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom));
    run_beats(0, -1, 1'b1, 400);
    checks++;
    if (timed_out || got_q.size() != 24) begin
      errors++;
      $display("FAIL rand_count: got %0d beats (timeout %0b) want 24", got_q.size(), timed_out);
    end
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (got_q[i] !== want_q[i]) begin
        errors++;
        $display("FAIL rand_value[%0d]: got %h want %h", i, got_q[i], want_q[i]);
      end
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL rand_hold: got %0d changes while stalled want 0", unstable);
    end
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1;
      a_i     = 32'(i + 1);
      b_i     = 32'h10;
      op_i    = 2'b00;
      cin_i   = 1'b0;
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (valid_o !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre_valid: got %b want 1", valid_o);
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || result_o !== 32'd0) begin
      errors++;
      $display("FAIL midreset_drop: got valid %b result %h want 0 0", valid_o, result_o);
    end
    @(negedge clk);
    rst_ni  = 1'b1;
    ready_i = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid_o) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL midreset_stale: got %0d valid cycles want 0", stale);
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: got %b want 1", ready_o);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    a_i     = '0;
    b_i     = '0;
    op_i    = 2'b00;
    cin_i   = 1'b0;
    test_reset();
    test_add_wrap();
    test_sub_ovf();
    test_backpressure();
    test_chain();
    test_back_to_back();
    test_random_stall();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 20000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/add_sub_pipe.md
Name: add_sub_pipe

Overview:
- Parametrised, pipelined successor to the team's single-cycle ripple add/subtract unit.
- Splits the WIDTH-bit carry chain into SEG_W-bit segments and resolves one segment per pipeline stage.
- Stages are joined by an elastic valid/ready pipeline, giving full throughput with backpressure.
- Adds carry-in chaining modes and full ALU flags. Sits between the operand-select logic and the writeback/flag register in the ALU datapath.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SEG_W.
- SEG_W, 8, bits resolved per stage. NSEG = WIDTH/SEG_W = pipeline depth = latency (1..WIDTH).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  operand beat valid.
- ready_o  out  1  unit can accept a beat this cycle.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- op_i  in  2  00 ADD (a+b), 01 SUB (a+~b+1), 10 ADDC (a+b+cin_i), 11 SUBB (a+~b+cin_i).
- cin_i  in  1  carry-in for ADDC/SUBB; ignored for ADD/SUB.
- valid_o  out  1  result beat valid.
- ready_i  in  1  consumer accepts the result.
- result_o  out  WIDTH  sum/difference, modulo 2^WIDTH.
- cout_o  out  1  carry out of bit WIDTH-1. For SUB/SUBB, 1 = no borrow.
- ovf_o  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero_o  out  1  result_o == 0.
- neg_o  out  1  result_o[WIDTH-1].

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All stage valid bits clear. valid_o=0.
  - result_o, cout_o, ovf_o, zero_o, neg_o all 0.
  - ready_o=1 as soon as rst_ni is high.
- Input handshake:
  - A beat is accepted when valid_i && ready_o at the clock edge.
  - a_i, b_i, op_i and cin_i are sampled only on acceptance.
  - The upstream may not drop valid_i before acceptance; the unit need not check this.
- Operand conditioning at acceptance:
  - bx = op_i[0] ? ~b_i : b_i.
  - c0 = (op_i==01) ? 1 : (op_i==00) ? 0 : cin_i.
- Stage k (0..NSEG-1) holds:
  - a, bx (upper segments only), partial result bits [k*SEG_W+SEG_W-1 : 0], running carry, valid.
  - Stage k adds segment k of a and bx plus the incoming carry.
  - Stage k may forward its lower segments' results untouched.
- Last stage:
  - Also records the carry into the MSB for ovf_o.
  - Its registers drive all outputs directly; zero_o is computed from the final result register, with no extra cycle.
- Advance rule:
  - Stage NSEG-1 loads when !v[NSEG-1] || ready_i.
  - Stage k<NSEG-1 loads when !v[k] || load[k+1].
  - ready_o = load[0].
  - A stage whose predecessor is empty while it loads clears its valid bit.
  - Only the valid bit is cleared; data registers hold their value (no enable glitching).
- Latency and throughput:
  - A beat accepted at edge t appears with valid_o=1 after edge t+NSEG-1, i.e. NSEG cycles through the registers.
  - Throughput is 1 beat/cycle while ready_i=1.
- Output hold: while valid_o && !ready_i, all outputs are stable. Up to NSEG beats are buffered, after which ready_o=0.
- Ordering: results always leave in acceptance order. No beat is lost or duplicated.
- Simultaneous accept and emit in the same cycle with a full pipe is legal and sustains full throughput.
- Reset mid-operation: all in-flight beats are discarded and valid_o drops immediately on rst_ni low.
- Degenerate config: SEG_W=WIDTH gives a single registered stage, latency 1.

Test Plan (WIDTH=32, SEG_W=8, NSEG=4):
- ADD 0xFFFF_FFFF+0x1 -> after 4 cycles result 0x0000_0000, cout 1, zero 1, ovf 0, neg 0.
- SUB 5-7 -> result 0xFFFF_FFFE, cout 0 (borrow), neg 1, ovf 0, zero 0.
- SUB 0x8000_0000-0x1 -> result 0x7FFF_FFFF, cout 1, ovf 1. Then ADDC 0x7FFF_FFFF+0+cin 1 -> result 0x8000_0000, ovf 1, neg 1.
- Backpressure:
  - Stimulus: stream 6 beats (ADD i+i*0x0101_0101, i=0..5) with ready_i low for cycles 3..8.
  - Response: ready_o falls after 4 beats are held. All 6 results appear in order with correct values and none lost. Outputs are stable while stalled.
- Chaining:
  - Stimulus: 64-bit add, ADD on low words 0xFFFF_FFFF+1, then ADDC on high words 0x1+0x0 with cin_i = previous cout.
  - Response: results 0x0 and 0x2.
- Reset: assert rst_ni low with 3 beats in flight -> valid_o=0 immediately, no stale results after release, ready_o=1.
